// File: rtl/pattern_scan_arbiter.sv
// Round-robin arbiter that time-shares one serial Moore pattern detector among
// NREQ requesters, scanning each granted word MSB first and reporting hit count/first position.
module pattern_scan_arbiter #(
  parameter int NREQ   = 4,
  parameter int WORD_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WORD_W-1:0]    req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      det_clr,
  output logic                      det_din,
  input  logic                      det_dout,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [$clog2(NREQ)-1:0]   resp_id,
  output logic [CNT_W-1:0]          resp_count,
  output logic [CNT_W-1:0]          resp_first
);

  localparam int ID_W = $clog2(NREQ);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] NO_HIT   = CNT_W'(WORD_W);
  localparam logic [ID_W-1:0]  LAST_REQ = ID_W'(NREQ - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, gnt_id, pick_id, cand;
  logic              pick_found, grant, hit, rst_q;
  logic [WORD_W-1:0] shreg, pick_word;
  logic [CNT_W-1:0]  count, first, bit_idx, hit_pos;

  // Search upward from rr_ptr, wrapping; first valid requester wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ID_W'((32'(rr_ptr) + k) % NREQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
    pick_word = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      if (ID_W'(i) == pick_id) pick_word = req_data[i*WORD_W +: WORD_W];
  end

  // Outputs are forced low while rst is high; rst_q also blocks a grant in the cycle after reset.
  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    req_ready  = '0;
    det_clr    = 1'b0;
    det_din    = 1'b0;
    resp_valid = 1'b0;
    resp_id    = '0;
    resp_count = '0;
    resp_first = '0;
    if (!rst) begin
      case (state)
        IDLE: if (pick_found && !rst_q) begin
          grant     = 1'b1;
          req_ready = NREQ'(1) << pick_id;
          state_nxt = CLEAR;
        end
        CLEAR: begin
          det_clr   = 1'b1;
          state_nxt = SHIFT;
        end
        SHIFT: begin
          det_din = shreg[WORD_W-1];
          if (bit_idx == LAST_IDX) state_nxt = DRAIN;
        end
        DRAIN: state_nxt = RESP;
        RESP: begin
          resp_valid = 1'b1;
          resp_id    = gnt_id;
          resp_count = count;
          resp_first = first;
          if (resp_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Detector output lags din by one cycle: in SHIFT it reports bit_idx-1, in DRAIN the last bit.
  assign hit     = det_dout && ((state == SHIFT && bit_idx != '0) || state == DRAIN);
  assign hit_pos = (state == DRAIN) ? LAST_IDX : bit_idx - CNT_W'(1);

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_id  <= '0;
      shreg   <= '0;
      count   <= '0;
      first   <= NO_HIT;
      bit_idx <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (grant) begin
          gnt_id <= pick_id;
          shreg  <= pick_word;
        end
        CLEAR: begin
          count   <= '0;
          first   <= NO_HIT;
          bit_idx <= '0;
        end
        SHIFT: begin
          shreg <= shreg << 1;
          if (bit_idx != LAST_IDX) bit_idx <= bit_idx + CNT_W'(1);
        end
        RESP: if (resp_ready) rr_ptr <= (gnt_id == LAST_REQ) ? '0 : gnt_id + ID_W'(1);
        default: ;
      endcase
      if (hit) begin
        if (count != '1) count <= count + CNT_W'(1);
        if (first == NO_HIT) first <= hit_pos;
      end
    end
  end

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// Self-checking bench for pattern_scan_arbiter with an overlapping "10101" Moore detector attached.
module tb_pattern_scan_arbiter;
  localparam int NREQ   = 4;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*WORD_W-1:0] req_data = '0;
  logic [NREQ-1:0]        req_ready;
  logic                   det_clr, det_din, det_dout;
  logic                   resp_valid;
  logic                   resp_ready = 1'b1;
  logic [1:0]             resp_id;
  logic [CNT_W-1:0]       resp_count, resp_first;
  logic [4:0]             hist = '0;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pattern_scan_arbiter #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .det_clr(det_clr), .det_din(det_din), .det_dout(det_dout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_count(resp_count), .resp_first(resp_first)
  );

  // Detector: last five bits received since clear, MSB oldest.
  always @(posedge clk) begin
    if (det_clr) hist <= '0;
    else         hist <= {hist[3:0], det_din};
  end
  assign det_dout = (hist == 5'b10101);

  // Five scan-order bits ending at scan position p (scan position 0 is the word MSB).
  function automatic logic [4:0] win(input logic [WORD_W-1:0] w, input int p);
    logic [4:0] v = '0;
    for (int j = p - 4; j <= p; j++) v = {v[3:0], w[WORD_W-1-j]};
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] ref_count(input logic [WORD_W-1:0] w);
    int n = 0;
    for (int p = 4; p < WORD_W; p++) if (win(w, p) == 5'b10101) n++;
    return (n > 31) ? '1 : CNT_W'(n);
  endfunction

  function automatic logic [CNT_W-1:0] ref_first(input logic [WORD_W-1:0] w);
    int f = WORD_W;
    for (int p = 4; p < WORD_W; p++) if (win(w, p) == 5'b10101 && f == WORD_W) f = p;
    return CNT_W'(f);
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req_valid = '0; resp_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  // Offers vmask/data until a grant, then drops req_valid and observes the job to its response.
  task automatic run_job(input logic [3:0] vmask, input logic [63:0] data, input bit scramble,
                         output logic [3:0] gv, output int lat, output logic [1:0] id,
                         output logic [4:0] cnt, output logic [4:0] fst, output logic [15:0] dseq,
                         output bit clr_ok, output bit quiet, output bit to);
    bit got = 0;
    gv = '0; lat = -1; id = '0; cnt = '0; fst = '0; dseq = '0; clr_ok = 0; quiet = 1; to = 0;
    resp_ready = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); req_valid = vmask; req_data = data; #1;
      if (req_ready != '0) begin gv = req_ready; got = 1; end
    end
    if (!got) begin
      to = 1;
      req_valid = '0;
    end else begin
      got = 0;
      for (int k = 1; k <= 40 && !got; k++) begin
        @(negedge clk);
        req_valid = '0;
        if (scramble) req_data = {$urandom, $urandom};
        #1;
        if (req_ready != '0) quiet = 0;
        if (k == 1) clr_ok = det_clr && !det_din;
        else if (det_clr) clr_ok = 0;
        if (k >= 2 && k <= 17) dseq = {dseq[14:0], det_din};
        if (resp_valid) begin lat = k; id = resp_id; cnt = resp_count; fst = resp_first; got = 1; end
      end
      if (!got) to = 1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; req_valid = '1; resp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({req_ready, resp_valid, det_din, det_clr, resp_id, resp_count, resp_first} !== 19'h0)
      $display("FAIL reset_cycle outputs got %h want 0", {req_ready, resp_valid, det_din, det_clr, resp_id, resp_count, resp_first});
    else passes++;
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({req_ready, resp_valid, det_din, det_clr, resp_id, resp_count, resp_first} !== 19'h0)
      $display("FAIL after_reset outputs got %h want 0", {req_ready, resp_valid, det_din, det_clr, resp_id, resp_count, resp_first});
    else passes++;
    @(negedge clk); req_valid = '0; #1;
    checks++;
    if (req_ready !== 4'b0000) $display("FAIL idle_no_valid req_ready got %b want 0000", req_ready);
    else passes++;
  endtask

  task automatic test_single();
    logic [3:0] gv; int lat; logic [1:0] id; logic [4:0] cnt, fst; logic [15:0] dseq;
    bit clr_ok, quiet, to;
    run_job(4'b0001, {48'h0, 16'h0015}, 0, gv, lat, id, cnt, fst, dseq, clr_ok, quiet, to);
    checks++; if (to !== 1'b0) $display("FAIL single_timeout got %0d want 0", to); else passes++;
    checks++; if (gv !== 4'b0001) $display("FAIL single_grant got %b want 0001", gv); else passes++;
    checks++; if (lat !== 19) $display("FAIL single_latency got %0d want 19", lat); else passes++;
    checks++; if (id !== 2'd0) $display("FAIL single_id got %0d want 0", id); else passes++;
    checks++; if (cnt !== ref_count(16'h0015)) $display("FAIL single_count got %0d want %0d", cnt, ref_count(16'h0015)); else passes++;
    checks++; if (fst !== ref_first(16'h0015)) $display("FAIL single_first got %0d want %0d", fst, ref_first(16'h0015)); else passes++;
    checks++; if (dseq !== 16'h0015) $display("FAIL single_din_stream got %h want 0015", dseq); else passes++;
    checks++; if (clr_ok !== 1'b1) $display("FAIL single_clear got %0d want 1", clr_ok); else passes++;
    checks++; if (quiet !== 1'b1) $display("FAIL single_ready_quiet got %0d want 1", quiet); else passes++;
  endtask

  task automatic test_overlap();
    logic [3:0] gv; int lat; logic [1:0] id; logic [4:0] cnt, fst; logic [15:0] dseq;
    bit clr_ok, quiet, to;
    logic [15:0] words [2];
    words[0] = 16'hAAAA; words[1] = 16'h0000;
    for (int n = 0; n < 2; n++) begin
      run_job(4'b0100, {16'h0, words[n], 32'h0}, 0, gv, lat, id, cnt, fst, dseq, clr_ok, quiet, to);
      checks++; if (gv !== 4'b0100 || to) $display("FAIL overlap_grant[%0d] got %b want 0100", n, gv); else passes++;
      checks++; if (id !== 2'd2) $display("FAIL overlap_id[%0d] got %0d want 2", n, id); else passes++;
      checks++; if (cnt !== ref_count(words[n])) $display("FAIL overlap_count[%0d] got %0d want %0d", n, cnt, ref_count(words[n])); else passes++;
      checks++; if (fst !== ref_first(words[n])) $display("FAIL overlap_first[%0d] got %0d want %0d", n, fst, ref_first(words[n])); else passes++;
    end
  endtask

  task automatic test_isolation();
    logic [3:0] gv; int lat; logic [1:0] id; logic [4:0] cnt, fst; logic [15:0] dseq;
    bit clr_ok, quiet, to;
    run_job(4'b0010, {32'h0, 16'h5555, 16'h0}, 1, gv, lat, id, cnt, fst, dseq, clr_ok, quiet, to);
    checks++; if (gv !== 4'b0010 || to) $display("FAIL iso_grant got %b want 0010", gv); else passes++;
    checks++; if (dseq !== 16'h5555) $display("FAIL iso_din_stream got %h want 5555", dseq); else passes++;
    checks++; if (cnt !== ref_count(16'h5555)) $display("FAIL iso_count got %0d want %0d", cnt, ref_count(16'h5555)); else passes++;
    checks++; if (fst !== ref_first(16'h5555)) $display("FAIL iso_first got %0d want %0d", fst, ref_first(16'h5555)); else passes++;
  endtask

  task automatic test_random();
    logic [3:0] gv; int lat; logic [1:0] id; logic [4:0] cnt, fst; logic [15:0] dseq;
    bit clr_ok, quiet, to;
    logic [63:0] d; logic [15:0] w; int r;
    for (int n = 0; n < 6; n++) begin
      r = $urandom_range(0, 3);
      w = ($urandom_range(0, 1) == 1) ? 16'($urandom) : (16'hAAAA ^ (16'h1 << $urandom_range(0, 15)));
      d = {$urandom, $urandom};
      d[r*16 +: 16] = w;
      run_job(4'(1 << r), d, 0, gv, lat, id, cnt, fst, dseq, clr_ok, quiet, to);
      checks++; if (gv !== 4'(1 << r) || lat !== 19) $display("FAIL rand_grant[%0d] got %b/%0d want %b/19", n, gv, lat, 4'(1 << r)); else passes++;
      checks++; if (id !== 2'(r)) $display("FAIL rand_id[%0d] got %0d want %0d", n, id, r); else passes++;
      checks++; if (cnt !== ref_count(w)) $display("FAIL rand_count[%0d] word %h got %0d want %0d", n, w, cnt, ref_count(w)); else passes++;
      checks++; if (fst !== ref_first(w)) $display("FAIL rand_first[%0d] word %h got %0d want %0d", n, w, fst, ref_first(w)); else passes++;
    end
  endtask

  task automatic test_round_robin();
    logic [63:0] d; logic [3:0] gv [5]; int gc [5]; logic [1:0] rid [5]; logic [4:0] rcnt [5];
    int ng = 0; int nr = 0;
    d = {$urandom, $urandom};
    do_reset();
    for (int cyc = 0; cyc < 150 && nr < 5; cyc++) begin
      @(negedge clk); req_valid = '1; req_data = d; resp_ready = 1'b1; #1;
      if (req_ready != '0 && ng < 5) begin gv[ng] = req_ready; gc[ng] = cyc; ng++; end
      if (resp_valid && nr < 5) begin rid[nr] = resp_id; rcnt[nr] = resp_count; nr++; end
    end
    @(negedge clk); req_valid = '0;
    checks++; if (ng !== 5 || nr !== 5) $display("FAIL rr_timeout grants %0d resps %0d want 5/5", ng, nr); else passes++;
    for (int i = 0; i < ng; i++) begin
      checks++; if (gv[i] !== 4'(1 << (i % 4))) $display("FAIL rr_grant[%0d] got %b want %b", i, gv[i], 4'(1 << (i % 4))); else passes++;
      if (i > 0) begin
        checks++; if (gc[i] - gc[i-1] !== 20) $display("FAIL rr_spacing[%0d] got %0d want 20", i, gc[i] - gc[i-1]); else passes++;
      end
    end
    for (int i = 0; i < nr; i++) begin
      checks++; if (rid[i] !== 2'(i % 4)) $display("FAIL rr_resp_id[%0d] got %0d want %0d", i, rid[i], i % 4); else passes++;
      checks++; if (rcnt[i] !== ref_count(d[(i % 4)*16 +: 16])) $display("FAIL rr_count[%0d] got %0d want %0d", i, rcnt[i], ref_count(d[(i % 4)*16 +: 16])); else passes++;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] d; bit got = 0; logic [4:0] ec, ef;
    d = {$urandom, $urandom};
    d[15:0] = 16'hAAAA ^ 16'($urandom_range(0, 3));
    ec = ref_count(d[15:0]); ef = ref_first(d[15:0]);
    do_reset();
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk); req_valid = '1; req_data = d; resp_ready = 1'b0; #1;
      if (resp_valid) got = 1;
    end
    checks++; if (got !== 1'b1) $display("FAIL bp_resp_timeout got %0d want 1", got); else passes++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++;
      if ({resp_valid, resp_id, resp_count, resp_first, req_ready, det_din} !== {1'b1, 2'd0, ec, ef, 4'b0000, 1'b0})
        $display("FAIL bp_hold[%0d] got %h want %h", c, {resp_valid, resp_id, resp_count, resp_first, req_ready, det_din},
                 {1'b1, 2'd0, ec, ef, 4'b0000, 1'b0});
      else passes++;
    end
    @(negedge clk); resp_ready = 1'b1; #1;
    checks++; if (resp_valid !== 1'b1) $display("FAIL bp_release_valid got %0d want 1", resp_valid); else passes++;
    @(negedge clk); #1;
    checks++; if (req_ready !== 4'b0010) $display("FAIL bp_next_grant got %b want 0010", req_ready); else passes++;
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk); req_valid = '0; #1;
      if (resp_valid) begin
        got = 1;
        checks++; if (resp_id !== 2'd1) $display("FAIL bp_second_id got %0d want 1", resp_id); else passes++;
      end
    end
    checks++; if (got !== 1'b1) $display("FAIL bp_second_timeout got %0d want 1", got); else passes++;
  endtask

  task automatic test_midscan_reset();
    logic [3:0] gv; int lat; logic [1:0] id; logic [4:0] cnt, fst; logic [15:0] dseq;
    bit clr_ok, quiet, to; bit got = 0;
    logic [63:0] d;
    d = '0; d[47:32] = 16'hAAAA;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk); req_valid = 4'b0100; req_data = d; resp_ready = 1'b1; #1;
      if (req_ready != '0) got = 1;
    end
    checks++; if (got !== 1'b1) $display("FAIL mid_grant_timeout got %0d want 1", got); else passes++;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); req_valid = '0;
      if (k == 10) rst = 1'b1;
      #1;
    end
    checks++;
    if ({req_ready, resp_valid, det_din, det_clr, resp_id, resp_count, resp_first} !== 19'h0)
      $display("FAIL mid_reset_cycle outputs got %h want 0", {req_ready, resp_valid, det_din, det_clr, resp_id, resp_count, resp_first});
    else passes++;
    @(negedge clk); rst = 1'b0; d[15:0] = 16'hAAAA; req_valid = 4'b0101; req_data = d; #1;
    checks++;
    if ({req_ready, resp_valid, det_din, det_clr, resp_id, resp_count, resp_first} !== 19'h0)
      $display("FAIL mid_after_reset outputs got %h want 0", {req_ready, resp_valid, det_din, det_clr, resp_id, resp_count, resp_first});
    else passes++;
    run_job(4'b0101, d, 0, gv, lat, id, cnt, fst, dseq, clr_ok, quiet, to);
    checks++; if (gv !== 4'b0001 || to) $display("FAIL mid_regrant got %b want 0001", gv); else passes++;
    checks++; if (lat !== 19) $display("FAIL mid_latency got %0d want 19", lat); else passes++;
    checks++; if (id !== 2'd0) $display("FAIL mid_id got %0d want 0", id); else passes++;
    checks++; if (cnt !== 5'd6) $display("FAIL mid_count got %0d want 6", cnt); else passes++;
    checks++; if (fst !== 5'd4) $display("FAIL mid_first got %0d want 4", fst); else passes++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_overlap();
    test_isolation();
    test_random();
    test_round_robin();
    test_backpressure();
    test_midscan_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pattern_scan_arbiter.md
# pattern_scan_arbiter

Shares a single serial Moore pattern detector (1-bit `din` in, 1-bit `dout` out) among `NREQ` requesters. Each requester submits a `WORD_W`-bit word. The block grants one requester at a time in round-robin order, clears the detector, and shifts the word in MSB first. It counts detector hits and returns the hit count and the position of the first hit on a valid/ready response channel. It sits between the requester bus and the detector instance.

## Interface
- `NREQ`, 4, number of requesters (≥2).
- `WORD_W`, 16, bits per scan word.
- `CNT_W`, 5, width of count/position fields; must satisfy 2^`CNT_W` > `WORD_W`.
- `clk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  `NREQ`  per-requester word available.
- `req_data`  in  `NREQ*WORD_W`  requester i word at bits [i*`WORD_W` +: `WORD_W`].
- `req_ready`  out  `NREQ`  one-hot accept strobe; the word transfers when `req_valid[i]` and `req_ready[i]` are both high.
- `det_clr`  out  1  active-high detector clear; integration inverts it onto the detector's `rst_n`.
- `det_din`  out  1  serial bit to the detector.
- `det_dout`  in  1  detector Moore output.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_id`  out  clog2(`NREQ`)  index of the requester that was served.
- `resp_count`  out  `CNT_W`  number of detector hits, saturating at all-ones.
- `resp_first`  out  `CNT_W`  index (0 = first bit shifted) of the bit whose arrival produced the first hit; `WORD_W` if there was no hit.

## Operation
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, RESP.
- **IDLE**
  - Search `req_valid` starting at `rr_ptr` and wrapping upward.
  - On the first set bit g: drive `req_ready[g]`=1 for this single cycle, latch the word and g, then go to CLEAR.
  - If no request is valid, stay in IDLE with `req_ready`=0.
- **CLEAR**: `det_clr`=1 and `det_din`=0 for one cycle. Clear `count` to 0, set `first` to `WORD_W`, set `bit_idx` to 0. Go to SHIFT.
- **SHIFT**
  - Drive `det_din` = word[`WORD_W`-1-`bit_idx`].
  - When `bit_idx`≥1, sample `det_dout`. A sampled 1 is a hit for bit `bit_idx`-1.
  - On a hit, increment `count`, saturating.
  - On the first hit, set `first` to `bit_idx`-1.
  - When `bit_idx`=`WORD_W`-1, go to DRAIN; otherwise increment `bit_idx`.
- **DRAIN**: `det_din`=0. Sample `det_dout` for bit `WORD_W`-1 using the same hit rules. Go to RESP.
- **RESP**
  - `resp_valid`=1. `resp_id`, `resp_count` and `resp_first` stay stable until the cycle with `resp_ready`=1.
  - On that cycle: `rr_ptr` ← (g+1) mod `NREQ`, then go to IDLE.
- `det_dout` is ignored in IDLE, CLEAR and RESP.
- Exactly one job is in flight at a time. No request is granted outside IDLE, so `req_ready` is 0 in every other state.
- After the grant, the latched word is used. Changes to `req_data` or `req_valid` after the grant have no effect on the job.

## Timing
- Grant cycle T (IDLE): `req_ready` high.
- T+1: CLEAR.
- T+2 … T+`WORD_W`+1: SHIFT.
- T+`WORD_W`+2: DRAIN.
- `resp_valid` first high at T+`WORD_W`+3 (T+19 for `WORD_W`=16).
- Minimum spacing between grants: `WORD_W`+4 cycles, reached when `resp_ready` is held high.
- Detector contract: the bit driven in cycle t is reflected on `det_dout` in cycle t+1. One bit is driven per cycle with no gaps.
- **Reset**, applied on any clock edge in any state, including mid-SHIFT or RESP:
  - state ← IDLE, `rr_ptr` ← 0, `count` ← 0, `first` ← `WORD_W`, `bit_idx` ← 0.
  - In the reset cycle and the cycle after: `req_ready`=0, `resp_valid`=0, `det_din`=0, `det_clr`=0, `resp_id`=0, `resp_count`=0, `resp_first`=0.
  - An aborted job produces no response. The next job always passes through CLEAR, so stale detector state is harmless.
- **Simultaneous events**
  - `req_valid` rising in the same cycle that RESP completes is not granted until the next IDLE cycle.
  - Multiple valid requests are resolved by `rr_ptr` only.

## Test plan
Integrated detector: overlapping "10101" Moore detector; `WORD_W`=16, `NREQ`=4.
- **Single job:** req 0 with 0x0015 → `req_ready`=4'b0001 at T; `resp_valid` at T+19 with `resp_id`=0, `resp_count`=1, `resp_first`=15.
- **Overlap counting:** req 2 with 0xAAAA → `resp_count`=6, `resp_first`=4. Then req 2 with 0x0000 → `resp_count`=0, `resp_first`=16.
- **Round-robin:** all four requesters valid continuously from reset → grants in order 0,1,2,3,0. Grants are spaced 20 cycles apart with `resp_ready`=1. `resp_id` sequence is 0,1,2,3,0.
- **Backpressure:** hold `resp_ready`=0 for 5 cycles after `resp_valid` rises → outputs are stable. Other requesters stay valid, yet there is no `req_ready` and `det_din`=0 throughout. The next grant occurs the cycle after `resp_ready`=1.
- **Mid-scan reset:** assert `rst` at bit 8 of 0xAAAA → next cycle all outputs are 0 and there is no response. Re-submitting 0xAAAA yields `resp_count`=6, and with `rr_ptr`=0 requester 0 has priority.
- **Stimulus isolation:** change `req_data` and drop `req_valid` the cycle after the grant → the response still reflects the latched word.
